imem_loader: RTL

//  Writer side of instruction memory: receives a program image as a byte stream, packs

---
 rtl/imem_loader_pkg.sv | 18 +
 rtl/imem_loader_if.sv | 31 +++
 rtl/imem_loader_byte_packer.sv | 35 +++
 rtl/imem_loader.sv | 134 +++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and framing constants for the instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLenLo,
        StLenHi,
        StData,
        StCsum,
        StDone,
        StErr
    } state_t;

    localparam int unsigned HDR_BYTES  = 2;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned WORD_W     = 8 * WORD_BYTES;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-link input and imem write port of the loader, bundled as one interface.
interface imem_loader_if;
    import imem_loader_pkg::*;

    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              wr_en;
    logic [WORD_W-1:0] wr_addr;
    logic [WORD_W-1:0] wr_data;

    // master: the loader itself; slave: host byte source plus imem write port
    modport master (
        input  rx_valid,
        input  rx_data,
        output rx_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );

    modport slave (
        output rx_valid,
        output rx_data,
        input  rx_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs a little-endian byte stream into 32-bit words; word_valid marks the 4th byte.
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              word_valid,
    output logic [WORD_W-1:0] word
);

    logic [1:0]        lane_q;
    logic [WORD_W-1:0] buf_q;

    assign word_valid = in_valid && (lane_q == 2'(WORD_BYTES - 1));

    // Completed word is visible combinationally so the top can register it on the same edge.
    always_comb begin
        word = buf_q;
        word[8*lane_q +: 8] = in_data;
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            lane_q <= '0;
            buf_q  <= '0;
        end else if (in_valid) begin
            lane_q <= lane_q + 2'd1;
            buf_q  <= word;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Receives a length-prefixed, checksummed program image and writes it into imem word by word.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned       DEPTH     = 64,
    parameter logic [WORD_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       CNT_W     = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    imem_loader_if.master bus,
    output logic         busy,
    output logic         done,
    output logic         err
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  len_q;
    logic [CNT_W-1:0]  word_idx_q;
    logic [7:0]        csum_q;
    logic              wr_en_q;
    logic [WORD_W-1:0] wr_addr_q;
    logic [WORD_W-1:0] wr_data_q;

    logic              rx_ready;
    logic              start_ok;
    logic [CNT_W-1:0]  len_full;
    logic              len_over;
    logic              last_word;
    logic              data_in;
    logic              word_valid;
    logic [WORD_W-1:0] word;

    assign start_ok  = start && (state_q == StIdle || state_q == StDone || state_q == StErr);
    assign len_full  = CNT_W'({bus.rx_data, len_q[7:0]});
    assign len_over  = 32'(len_full) > DEPTH;
    assign last_word = (word_idx_q == len_q - CNT_W'(1));
    assign data_in   = bus.rx_valid && (state_q == StData);

    imem_loader_byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (start_ok),
        .in_valid   (data_in),
        .in_data    (bus.rx_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // rx_ready is high in every receiving state, so rx_valid alone marks a transfer there.
    always_comb begin
        state_d  = state_q;
        rx_ready = 1'b0;
        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start) state_d = StLenLo;
            end
            StLenLo: begin
                rx_ready = 1'b1;
                if (bus.rx_valid) state_d = StLenHi;
            end
            StLenHi: begin
                rx_ready = 1'b1;
                if (bus.rx_valid) begin
                    if (len_over) begin
                        state_d = StErr;
                    end else if (len_full == '0) begin
                        state_d = StCsum;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                rx_ready = 1'b1;
                if (bus.rx_valid && word_valid && last_word) state_d = StCsum;
            end
            StCsum: begin
                rx_ready = 1'b1;
                if (bus.rx_valid) state_d = (bus.rx_data == csum_q) ? StDone : StErr;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len_q      <= '0;
            word_idx_q <= '0;
            csum_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            wr_en_q <= 1'b0;
            if (start_ok) begin
                len_q      <= '0;
                word_idx_q <= '0;
                csum_q     <= '0;
            end
            if (bus.rx_valid && state_q == StLenLo) len_q[7:0] <= bus.rx_data;
            if (bus.rx_valid && state_q == StLenHi) len_q <= len_full;
            if (data_in) begin
                csum_q <= csum_q + bus.rx_data;
                if (word_valid) begin
                    wr_en_q    <= 1'b1;
                    wr_addr_q  <= BASE_ADDR + (WORD_W'(word_idx_q) << 2);
                    wr_data_q  <= word;
                    word_idx_q <= word_idx_q + CNT_W'(1);
                end
            end
        end
    end

    assign bus.rx_ready = rx_ready;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;

    assign busy = (state_q == StLenLo) || (state_q == StLenHi) ||
                  (state_q == StData)  || (state_q == StCsum);
    assign done = (state_q == StDone);
    assign err  = (state_q == StErr);

endmodule
